// File: rtl/game_pkg.sv
// Shared types and constants for the game input path.
// Pause FSM encoding and debounce timing defaults.
package game_pkg;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      PAUSE_PEND  = 2'd1,
      PAUSED      = 2'd2,
      RESUME_PEND = 2'd3
   } pause_st_t;

   localparam int N_SW_DEFAULT       = 8;
   localparam int DEB_CYCLES_DEFAULT = 1_000_000;
   localparam int CNT_W_DEFAULT      = 20;
   localparam int SIM_DEB_CYCLES     = 4;

   // True when a CNT_W-bit counter can reach deb-1.
   function automatic bit cnt_w_ok(input int deb, input int w);
      return (64'(1) << w) > 64'(deb);
   endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Board-input bundle between the raw pins and the conditioner.
// master = board/stimulus side, slave = input_conditioner.
interface input_conditioner_if #(
   parameter int N_SW = 8
);
   logic            i_pause_btn;
   logic [N_SW-1:0] i_sw;
   logic            i_frame_end;
   logic [N_SW-1:0] o_sw;
   logic [N_SW-1:0] o_sw_rise;
   logic            o_pause_pulse;
   logic            o_paused;
   logic            o_run;

   modport master (
      output i_pause_btn,
      output i_sw,
      output i_frame_end,
      input  o_sw,
      input  o_sw_rise,
      input  o_pause_pulse,
      input  o_paused,
      input  o_run
   );

   modport slave (
      input  i_pause_btn,
      input  i_sw,
      input  i_frame_end,
      output o_sw,
      output o_sw_rise,
      output o_pause_pulse,
      output o_paused,
      output o_run
   );
endinterface

// File: rtl/input_conditioner_debounce_ch.sv
// One input channel: 2-FF synchroniser, hold-time debounce,
// registered one-cycle rising-edge pulse.
module debounce_ch
   import game_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic CLK,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   if (!cnt_w_ok(DEB_CYCLES, CNT_W)) begin : g_bad_w
      $error("CNT_W too narrow for DEB_CYCLES");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             stable_q;
   logic             rise_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Counter only runs while s2 disagrees; any return clears it.
   always_ff @(posedge CLK) begin
      if (rst) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
      end else if (s2_q == stable_q) begin
         cnt_q  <= '0;
         rise_q <= 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         stable_q <= s2_q;
         cnt_q    <= '0;
         rise_q   <= s2_q;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
         rise_q <= 1'b0;
      end
   end

   assign level = stable_q;
   assign rise  = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces switches and pause button; runs the frame-aligned
// run/pause state machine feeding the VGA game core.
module input_conditioner
   import game_pkg::*;
#(
   parameter int N_SW       = N_SW_DEFAULT,
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input logic          CLK,
   input logic          rst,
   input_conditioner_if.slave bus
);

   logic [N_SW-1:0] sw_level;
   logic [N_SW-1:0] sw_rise;
   logic            pause_level;
   logic            pause_pulse;

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_ch #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W)
      ) u_sw (
         .CLK   (CLK),
         .rst   (rst),
         .raw   (bus.i_sw[i]),
         .level (sw_level[i]),
         .rise  (sw_rise[i])
      );
   end

   debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_pause (
      .CLK   (CLK),
      .rst   (rst),
      .raw   (bus.i_pause_btn),
      .level (pause_level),
      .rise  (pause_pulse)
   );

   pause_st_t state_q;
   pause_st_t state_d;
   logic      paused;

   always_ff @(posedge CLK) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // A press wins over frame_end; frame_end only commits pending.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (pause_pulse) state_d = PAUSE_PEND;
         end
         PAUSE_PEND: begin
            if (pause_pulse)          state_d = RUN;
            else if (bus.i_frame_end) state_d = PAUSED;
         end
         PAUSED: begin
            if (pause_pulse) state_d = RESUME_PEND;
         end
         RESUME_PEND: begin
            if (pause_pulse)          state_d = PAUSED;
            else if (bus.i_frame_end) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      paused = 1'b0;
      unique case (state_q)
         PAUSED, RESUME_PEND: paused = 1'b1;
         default:             paused = 1'b0;
      endcase
   end

   assign bus.o_sw          = sw_level;
   assign bus.o_sw_rise     = sw_rise;
   assign bus.o_pause_pulse = pause_pulse;
   assign bus.o_paused      = paused;
   assign bus.o_run         = ~paused;

   logic unused_level;
   assign unused_level = pause_level;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce.
// Inputs change and outputs are sampled 1 ns after posedge.
module tb_input_conditioner;
   import game_pkg::*;

   localparam int N_SW = 8;

   logic CLK = 1'b0;
   logic rst = 1'b1;

   always #5 CLK = ~CLK;

   input_conditioner_if #(.N_SW(N_SW)) bus ();

   input_conditioner #(
      .N_SW       (N_SW),
      .DEB_CYCLES (SIM_DEB_CYCLES),
      .CNT_W      (3)
   ) dut (
      .CLK (CLK),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Waits for the pause pulse, bounded; checks its latency.
   task automatic wait_pulse(input string tag, input int exp_n);
      int n;
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.o_pause_pulse) begin
            n = k;
            break;
         end
      end
      chk(tag, 32'(n), 32'(exp_n));
   endtask

   task automatic release_btn();
      bus.i_pause_btn = 1'b0;
      repeat (8) tick();
   endtask

   int rises;

   initial begin
      bus.i_pause_btn = 1'b0;
      bus.i_sw        = '0;
      bus.i_frame_end = 1'b0;

      // 1: reset and idle
      repeat (3) tick();
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("t1_sw", 32'(bus.o_sw), 32'h00);
         chk("t1_rise", 32'(bus.o_sw_rise), 32'h00);
         chk("t1_pp", 32'(bus.o_pause_pulse), 32'h0);
         chk("t1_paused", 32'(bus.o_paused), 32'h0);
         chk("t1_run", 32'(bus.o_run), 32'h1);
      end

      // 2: sw[3] rises and holds
      bus.i_sw[3] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("t2_sw", 32'(bus.o_sw), (k >= 6) ? 32'h08 : 32'h00);
         chk("t2_rise", 32'(bus.o_sw_rise), (k == 6) ? 32'h08 : 32'h00);
      end

      // 3: sw[0] bounces then settles high
      rises = 0;
      for (int i = 0; i < 4; i++) begin
         bus.i_sw[0] = (i % 2 == 0);
         tick();
         chk("t3_bounce_sw", 32'(bus.o_sw), 32'h08);
         if (bus.o_sw_rise[0]) rises++;
      end
      bus.i_sw[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("t3_sw", 32'(bus.o_sw), (k >= 6) ? 32'h09 : 32'h08);
         chk("t3_rise", 32'(bus.o_sw_rise), (k == 6) ? 32'h01 : 32'h00);
         if (bus.o_sw_rise[0]) rises++;
      end
      chk("t3_nrise", 32'(rises), 32'd1);

      // 4: held press, frame-aligned pause, then resume
      bus.i_pause_btn = 1'b1;
      wait_pulse("t4_lat", 6);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t4_pp_once", 32'(bus.o_pause_pulse), 32'h0);
         chk("t4_pend", 32'(bus.o_paused), 32'h0);
      end
      bus.i_frame_end = 1'b1;
      chk("t4_pre_fe", 32'(bus.o_paused), 32'h0);
      tick();
      bus.i_frame_end = 1'b0;
      chk("t4_paused", 32'(bus.o_paused), 32'h1);
      chk("t4_run", 32'(bus.o_run), 32'h0);
      for (int k = 0; k < 33; k++) begin
         tick();
         chk("t4_hold", 32'(bus.o_pause_pulse), 32'h0);
      end
      release_btn();
      bus.i_pause_btn = 1'b1;
      wait_pulse("t4_lat2", 6);
      tick();
      chk("t4_rpend_st", 32'(dut.state_q), 32'(RESUME_PEND));
      chk("t4_rpend", 32'(bus.o_paused), 32'h1);
      bus.i_frame_end = 1'b1;
      tick();
      bus.i_frame_end = 1'b0;
      chk("t4_resumed", 32'(bus.o_paused), 32'h0);
      chk("t4_run2", 32'(bus.o_run), 32'h1);
      release_btn();

      // 5: two presses cancel before frame_end
      bus.i_pause_btn = 1'b1;
      wait_pulse("t5_lat1", 6);
      tick();
      chk("t5_pend_st", 32'(dut.state_q), 32'(PAUSE_PEND));
      chk("t5_pend", 32'(bus.o_paused), 32'h0);
      release_btn();
      bus.i_pause_btn = 1'b1;
      wait_pulse("t5_lat2", 6);
      tick();
      chk("t5_cancel_st", 32'(dut.state_q), 32'(RUN));
      bus.i_frame_end = 1'b1;
      tick();
      bus.i_frame_end = 1'b0;
      chk("t5_paused", 32'(bus.o_paused), 32'h0);
      chk("t5_st", 32'(dut.state_q), 32'(RUN));
      release_btn();

      // 6: press coincides with frame_end, then reset mid-pending
      bus.i_pause_btn = 1'b1;
      wait_pulse("t6_lat", 6);
      bus.i_frame_end = 1'b1;
      tick();
      bus.i_frame_end = 1'b0;
      chk("t6_st", 32'(dut.state_q), 32'(PAUSE_PEND));
      chk("t6_paused", 32'(bus.o_paused), 32'h0);
      bus.i_sw[5] = 1'b1;
      repeat (3) tick();
      chk("t6_cnt_mid", 32'(dut.g_sw[5].u_sw.cnt_q), 32'd1);
      rst = 1'b1;
      tick();
      chk("t6_rst_st", 32'(dut.state_q), 32'(RUN));
      chk("t6_rst_paused", 32'(bus.o_paused), 32'h0);
      chk("t6_rst_run", 32'(bus.o_run), 32'h1);
      chk("t6_rst_cnt", 32'(dut.g_sw[5].u_sw.cnt_q), 32'd0);
      chk("t6_rst_sw", 32'(bus.o_sw), 32'h00);
      rst = 1'b0;
      tick();
      chk("t6_post_pp", 32'(bus.o_pause_pulse), 32'h0);
      chk("t6_post_rise", 32'(bus.o_sw_rise), 32'h00);
      chk("t6_post_sw", 32'(bus.o_sw), 32'h00);

      bus.i_pause_btn = 1'b0;
      bus.i_sw        = '0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
